// File: rtl/global_pkg.sv
// Shared types for the execution stages: memory op encoding, LSU states,
// funct3 size codes and the lane/alignment helpers used by the load/store unit.
package global_pkg;

    typedef enum logic [1:0] {
        MEM_NONE   = 2'd0,
        LOAD_DATA  = 2'd1,
        STORE_DATA = 2'd2
    } memory_operation_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Reserved size codes fall into the default arm and behave like words.
    function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: lane_sel = 4'b0001 << a;
            F3_H, F3_HU: lane_sel = a[1] ? 4'b1100 : 4'b0011;
            default:     lane_sel = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_B, F3_BU: is_misaligned = 1'b0;
            F3_H, F3_HU: is_misaligned = a[0];
            default:     is_misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: moves the addressed byte/halfword down to
// bit 0 and sign- or zero-extends it for the register file.
module load_align
    import global_pkg::*;
(
    input  logic [31:0] wb_dat_i,
    input  logic [1:0]  ea_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = wb_dat_i >> {ea_lo_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'b0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'b0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store execution stage: one Wishbone classic access per cyc/ack
// request, with misalignment, bus-error and timeout reporting.
module load_store_unit
    import global_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cyc,
    output logic              ack,
    input  memory_operation_t memory_operation,
    input  logic [2:0]        funct3,
    input  logic [31:0]       base_addr,
    input  logic [31:0]       offset,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              misaligned,
    output logic              bus_error,
    output logic [ADDR_W-1:0] wb_adr_o,
    output logic [31:0]       wb_dat_o,
    input  logic [31:0]       wb_dat_i,
    output logic [3:0]        wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    input  logic              wb_err_i
);

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    lsu_state_t        state_q, state_d;
    logic [1:0]        ea_lo_q, ea_lo_d;
    logic [2:0]        f3_q, f3_d;
    logic              store_q, store_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_error_q, bus_error_d;
    logic [ADDR_W-1:0] wb_adr_q, wb_adr_d;
    logic [31:0]       wb_dat_q, wb_dat_d;
    logic [3:0]        wb_sel_q, wb_sel_d;
    logic              wb_we_q, wb_we_d;
    logic              wb_cyc_q, wb_cyc_d;

    logic [31:0] ea;
    logic [31:0] aligned_data;
    logic        timeout_hit;

    assign ea          = base_addr + offset;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TMO_LAST);

    load_align u_load_align (
        .wb_dat_i (wb_dat_i),
        .ea_lo_i  (ea_lo_q),
        .funct3_i (f3_q),
        .data_o   (aligned_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ea_lo_q      <= 2'b00;
            f3_q         <= 3'b000;
            store_q      <= 1'b0;
            cnt_q        <= 32'd0;
            load_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
            bus_error_q  <= 1'b0;
            wb_adr_q     <= '0;
            wb_dat_q     <= 32'd0;
            wb_sel_q     <= 4'b0000;
            wb_we_q      <= 1'b0;
            wb_cyc_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            ea_lo_q      <= ea_lo_d;
            f3_q         <= f3_d;
            store_q      <= store_d;
            cnt_q        <= cnt_d;
            load_data_q  <= load_data_d;
            misaligned_q <= misaligned_d;
            bus_error_q  <= bus_error_d;
            wb_adr_q     <= wb_adr_d;
            wb_dat_q     <= wb_dat_d;
            wb_sel_q     <= wb_sel_d;
            wb_we_q      <= wb_we_d;
            wb_cyc_q     <= wb_cyc_d;
        end
    end

    // BUS ignores cyc so an abandoned request still completes its Wishbone cycle.
    always_comb begin
        state_d      = state_q;
        ea_lo_d      = ea_lo_q;
        f3_d         = f3_q;
        store_d      = store_q;
        cnt_d        = cnt_q;
        load_data_d  = load_data_q;
        misaligned_d = misaligned_q;
        bus_error_d  = bus_error_q;
        wb_adr_d     = wb_adr_q;
        wb_dat_d     = wb_dat_q;
        wb_sel_d     = wb_sel_q;
        wb_we_d      = wb_we_q;
        wb_cyc_d     = wb_cyc_q;
        case (state_q)
            IDLE: begin
                if (cyc && memory_operation != MEM_NONE) begin
                    ea_lo_d     = ea[1:0];
                    f3_d        = funct3;
                    store_d     = (memory_operation == STORE_DATA);
                    wb_adr_d    = {ea[ADDR_W-1:2], 2'b00};
                    wb_sel_d    = lane_sel(funct3, ea[1:0]);
                    wb_dat_d    = store_data << {ea[1:0], 3'b000};
                    load_data_d = 32'd0;
                    bus_error_d = 1'b0;
                    cnt_d       = 32'd0;
                    if (is_misaligned(funct3, ea[1:0])) begin
                        misaligned_d = 1'b1;
                        state_d      = DONE;
                    end else begin
                        wb_cyc_d = 1'b1;
                        wb_we_d  = (memory_operation == STORE_DATA);
                        state_d  = BUS;
                    end
                end
            end
            BUS: begin
                cnt_d = cnt_q + 32'd1;
                if (wb_err_i || timeout_hit) begin
                    wb_cyc_d    = 1'b0;
                    wb_we_d     = 1'b0;
                    bus_error_d = 1'b1;
                    load_data_d = 32'd0;
                    state_d     = DONE;
                end else if (wb_ack_i) begin
                    wb_cyc_d = 1'b0;
                    wb_we_d  = 1'b0;
                    if (!store_q) begin
                        load_data_d = aligned_data;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!cyc) begin
                    misaligned_d = 1'b0;
                    bus_error_d  = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack        = (state_q == DONE);
    assign load_data  = load_data_q;
    assign misaligned = misaligned_q;
    assign bus_error  = bus_error_q;
    assign wb_adr_o   = wb_adr_q;
    assign wb_dat_o   = wb_dat_q;
    assign wb_sel_o   = wb_sel_q;
    assign wb_we_o    = wb_we_q;
    assign wb_cyc_o   = wb_cyc_q;
    assign wb_stb_o   = wb_cyc_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a behavioural Wishbone
// slave (zero-wait ack, silent, or err+ack).
module tb_load_store_unit;
    import global_pkg::*;

    typedef struct {
        logic [31:0] loadData;
        logic        mis;
        logic        berr;
        int          latency;
        int          cycHigh;
    } resp_t;

    typedef struct {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } bus_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cyc = 1'b0;
    logic              ack;
    memory_operation_t memory_operation = MEM_NONE;
    logic [2:0]        funct3 = 3'b000;
    logic [31:0]       base_addr = 32'd0;
    logic [31:0]       offset = 32'd0;
    logic [31:0]       store_data = 32'd0;
    logic [31:0]       load_data;
    logic              misaligned;
    logic              bus_error;
    logic [31:0]       wb_adr_o;
    logic [31:0]       wb_dat_o;
    logic [31:0]       wb_dat_i = 32'd0;
    logic [3:0]        wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_ack_i = 1'b0;
    logic              wb_err_i = 1'b0;

    int    checks = 0;
    int    errors = 0;
    int    slaveMode = 0;
    int    busStarts = 0;
    int    startsBefore;
    resp_t respQ[$];
    bus_t  busQ[$];

    load_store_unit #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cyc              (cyc),
        .ack              (ack),
        .memory_operation (memory_operation),
        .funct3           (funct3),
        .base_addr        (base_addr),
        .offset           (offset),
        .store_data       (store_data),
        .load_data        (load_data),
        .misaligned       (misaligned),
        .bus_error        (bus_error),
        .wb_adr_o         (wb_adr_o),
        .wb_dat_o         (wb_dat_o),
        .wb_dat_i         (wb_dat_i),
        .wb_sel_o         (wb_sel_o),
        .wb_we_o          (wb_we_o),
        .wb_cyc_o         (wb_cyc_o),
        .wb_stb_o         (wb_stb_o),
        .wb_ack_i         (wb_ack_i),
        .wb_err_i         (wb_err_i)
    );

    always #5 clk = ~clk;

    always @(posedge wb_cyc_o) busStarts++;

    // Slave answers on the negedge after it sees a cycle; mode 1 never answers, mode 2 raises err with ack.
    always @(negedge clk) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (wb_cyc_o && wb_stb_o) begin
            if (slaveMode == 0) begin
                wb_ack_i = 1'b1;
            end else if (slaveMode == 2) begin
                wb_ack_i = 1'b1;
                wb_err_i = 1'b1;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input memory_operation_t op, input logic [2:0] f3,
                                 input logic [31:0] base, input logic [31:0] off,
                                 input logic [31:0] sdata, input logic [31:0] rdata,
                                 input logic pushResp, input logic [31:0] expLoad,
                                 input logic expMis, input logic expBerr,
                                 input int expLat, input int expCycHigh);
        logic [31:0] ea;
        logic [1:0]  lo;
        resp_t r;
        bus_t  b;
        @(negedge clk);
        memory_operation = op;
        funct3     = f3;
        base_addr  = base;
        offset     = off;
        store_data = sdata;
        wb_dat_i   = rdata;
        cyc        = 1'b1;
        ea = base + off;
        lo = ea[1:0];
        if (pushResp) begin
            r.loadData = expLoad;
            r.mis      = expMis;
            r.berr     = expBerr;
            r.latency  = expLat;
            r.cycHigh  = expCycHigh;
            respQ.push_back(r);
            if (!expMis) begin
                b.adr = {ea[31:2], 2'b00};
                case (f3)
                    F3_B, F3_BU: b.sel = 4'b0001 << lo;
                    F3_H, F3_HU: b.sel = lo[1] ? 4'b1100 : 4'b0011;
                    default:     b.sel = 4'b1111;
                endcase
                b.dat = sdata << (8 * lo);
                b.we  = (op == STORE_DATA);
                busQ.push_back(b);
            end
        end
    endtask

    task automatic checkOutput(input string tag, input int holdCycles);
        int    edges = 0;
        int    cycHigh = 0;
        resp_t r;
        bus_t  b;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (wb_cyc_o) begin
                if (cycHigh == 0 && busQ.size() > 0) begin
                    b = busQ.pop_front();
                    checkValue({tag, ".adr"}, wb_adr_o, b.adr);
                    checkValue({tag, ".sel"}, {28'd0, wb_sel_o}, {28'd0, b.sel});
                    checkValue({tag, ".dat"}, wb_dat_o, b.dat);
                    checkValue({tag, ".we"}, {31'd0, wb_we_o}, {31'd0, b.we});
                end
                cycHigh++;
            end
            if (ack) break;
        end
        checkValue({tag, ".ackSeen"}, {31'd0, ack}, 32'd1);
        checkValue({tag, ".busLeft"}, busQ.size(), 0);
        busQ.delete();
        if (respQ.size() > 0) begin
            r = respQ.pop_front();
            checkValue({tag, ".latency"}, edges, r.latency);
            checkValue({tag, ".cycHigh"}, cycHigh, r.cycHigh);
            checkValue({tag, ".loadData"}, load_data, r.loadData);
            checkValue({tag, ".mis"}, {31'd0, misaligned}, {31'd0, r.mis});
            checkValue({tag, ".berr"}, {31'd0, bus_error}, {31'd0, r.berr});
            repeat (holdCycles) @(negedge clk);
            checkValue({tag, ".ackHeld"}, {31'd0, ack}, 32'd1);
            checkValue({tag, ".dataHeld"}, load_data, r.loadData);
        end
        cyc = 1'b0;
        memory_operation = MEM_NONE;
        @(negedge clk);
        checkValue({tag, ".ackClear"}, {30'd0, ack, misaligned | bus_error}, 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        #2;
        checkValue("reset.ctrl", {26'd0, ack, misaligned, bus_error, wb_cyc_o, wb_stb_o, wb_we_o}, 32'd0);
        checkValue("reset.data", load_data | wb_adr_o | wb_dat_o | {28'd0, wb_sel_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        slaveMode = 0;
        applyStimulus(STORE_DATA, F3_W, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 1, 32'h0, 0, 0, 2, 1);
        checkOutput("SW", 3);
        applyStimulus(LOAD_DATA, F3_B, 32'h100, 32'h3, 32'h0, 32'h80123456, 1, 32'hFFFFFF80, 0, 0, 2, 1);
        checkOutput("LB", 1);
        applyStimulus(LOAD_DATA, F3_BU, 32'h100, 32'h3, 32'h0, 32'h80123456, 1, 32'h00000080, 0, 0, 2, 1);
        checkOutput("LBU", 1);
        applyStimulus(STORE_DATA, F3_H, 32'h100, 32'h2, 32'h0000ABCD, 32'h0, 1, 32'h0, 0, 0, 2, 1);
        checkOutput("SH", 1);
        applyStimulus(LOAD_DATA, F3_HU, 32'h100, 32'h2, 32'h0, 32'hABCD0000, 1, 32'h0000ABCD, 0, 0, 2, 1);
        checkOutput("LHU", 1);
        applyStimulus(LOAD_DATA, F3_H, 32'h100, 32'h2, 32'h0, 32'hABCD0000, 1, 32'hFFFFABCD, 0, 0, 2, 1);
        checkOutput("LH", 1);
        applyStimulus(LOAD_DATA, F3_W, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h12345678, 1, 32'h12345678, 0, 0, 2, 1);
        checkOutput("LWwrap", 1);
        applyStimulus(STORE_DATA, F3_B, 32'h101, 32'h0, 32'h000000A5, 32'h0, 1, 32'h0, 0, 0, 2, 1);
        checkOutput("SB", 1);

        startsBefore = busStarts;
        applyStimulus(LOAD_DATA, F3_W, 32'h100, 32'h1, 32'h0, 32'h11111111, 1, 32'h0, 1, 0, 1, 0);
        checkOutput("LWmis", 2);
        applyStimulus(LOAD_DATA, F3_H, 32'h100, 32'h3, 32'h0, 32'h11111111, 1, 32'h0, 1, 0, 1, 0);
        checkOutput("LHmis", 1);
        checkValue("mis.noBus", busStarts, startsBefore);
        applyStimulus(STORE_DATA, F3_W, 32'h104, 32'h0, 32'h01020304, 32'h0, 1, 32'h0, 0, 0, 2, 1);
        checkOutput("SWb2b", 4);
        checkValue("b2b.oneBus", busStarts, startsBefore + 1);

        slaveMode = 1;
        applyStimulus(LOAD_DATA, F3_W, 32'h100, 32'h0, 32'h0, 32'h55555555, 1, 32'h0, 0, 1, 17, 16);
        checkOutput("timeout", 1);

        slaveMode = 2;
        applyStimulus(LOAD_DATA, F3_W, 32'h100, 32'h0, 32'h0, 32'h66666666, 1, 32'h0, 0, 1, 2, 1);
        checkOutput("errAck", 1);
        slaveMode = 0;

        startsBefore = busStarts;
        @(negedge clk);
        memory_operation = MEM_NONE;
        cyc = 1'b1;
        repeat (3) @(negedge clk);
        checkValue("memNone.ack", {31'd0, ack}, 32'd0);
        checkValue("memNone.noBus", busStarts, startsBefore);
        cyc = 1'b0;

        slaveMode = 1;
        applyStimulus(LOAD_DATA, F3_W, 32'h100, 32'h0, 32'h0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #2;
        checkValue("rst.cycBefore", {31'd0, wb_cyc_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkValue("rst.cycAsync", {30'd0, wb_cyc_o, wb_stb_o}, 32'd0);
        cyc = 1'b0;
        memory_operation = MEM_NONE;
        repeat (2) @(negedge clk);
        checkValue("rst.noAck", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        slaveMode = 0;
        applyStimulus(LOAD_DATA, F3_W, 32'h200, 32'h0, 32'h0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 0, 0, 2, 1);
        checkOutput("LWafterRst", 1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Downstream execution stage for LOAD/STORE instructions. Consumes the control unit's cyc/memory_operation request and returns a level ack.
- Masters a 32-bit Wishbone classic bus with a single outstanding access.
- Aligns and sign-extends load data for the register file write path.
- Flags misaligned accesses and bus errors/timeouts instead of hanging the core.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles in BUS state without wb_ack/wb_err before forced termination; 0 disables the timeout.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  core clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- cyc  in  1  request from control unit, level, held until ack seen
- ack  out  1  completion, level, held until cyc deasserted
- memory_operation  in  memory_operation_t  MEM_NONE / LOAD_DATA / STORE_DATA
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- base_addr  in  32  rs1 value
- offset  in  32  sign-extended immediate (I for loads, S for stores, selected upstream)
- store_data  in  32  rs2 value
- load_data  out  32  aligned/extended load result, valid while ack=1
- misaligned  out  1  qualifies ack: access not naturally aligned, no bus cycle issued
- bus_error  out  1  qualifies ack: wb_err or timeout
- wb_adr_o  out  ADDR_W  word-aligned address, bits[1:0]=0
- wb_dat_o  out  32  lane-shifted store data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte lane enables
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe, equal to wb_cyc_o
- wb_ack_i  in  1  slave ack
- wb_err_i  in  1  slave error

Behaviour:
- Reset, asynchronous and independent of clk: state=IDLE; ack, misaligned, bus_error, wb_cyc_o, wb_stb_o and wb_we_o are 0; load_data, wb_adr_o, wb_dat_o and wb_sel_o are 0; timeout counter is 0.
- Reset mid-transaction aborts the bus cycle immediately. wb_cyc_o falls asynchronously and no ack is produced.
- Effective address ea = base_addr + offset, modulo 2^32 (wraps, no overflow flag).
- Alignment rule: halfword needs ea[0]=0; word needs ea[1:0]=0.
- Lane select: B gives sel=1<<ea[1:0]; H gives sel=0011 or 1100 by ea[1]; W gives sel=1111.
- Store lane shift: wb_dat_o = store_data << (8*ea[1:0]).
- Load extract: shift wb_dat_i right by 8*ea[1:0], then sign- or zero-extend per funct3[2].
- Reserved funct3 values (011, 11x) are treated as W for address/sel; result is undefined but the handshake completes.
- FSM IDLE:
  - On posedge with cyc=1 and memory_operation!=MEM_NONE, latch ea, funct3, op and lanes.
  - If misaligned, go to DONE with misaligned=1 and no bus cycle.
  - Otherwise go to BUS: assert wb_cyc_o/wb_stb_o, wb_we_o=(op==STORE_DATA), clear the counter.
  - cyc=1 with MEM_NONE is ignored and the FSM stays in IDLE.
- FSM BUS:
  - Counter increments each cycle.
  - On wb_ack_i: capture the formatted load_data (loads only), drop wb_cyc_o/wb_stb_o next edge, go to DONE.
  - On wb_err_i, or counter==TIMEOUT_CYCLES-1 with TIMEOUT_CYCLES!=0: drop the bus, set bus_error=1, load_data=0, go to DONE.
  - wb_ack_i and wb_err_i together: err wins.
- FSM DONE:
  - ack=1 together with load_data/misaligned/bus_error, all held stable.
  - When cyc is sampled 0, go to IDLE; ack, misaligned and bus_error clear on that edge.
  - This guarantees one bus access per request even if the next request is back-to-back; a new request needs cyc low for at least one posedge.
- Latency, aligned access with zero-wait slave: request edge to BUS (1), wb_ack edge to DONE (1). ack rises 2 posedges after cyc is sampled.
- Latency, misaligned: ack rises 1 posedge after cyc is sampled.
- Control unit samples ack on negedge. ack is registered on posedge and is therefore stable at every negedge.
- cyc dropping while in BUS (abandoned request): finish the bus cycle, then go to DONE→IDLE with ack seen low. Never abort a Wishbone cycle mid-flight.

Decomposition:
- global_pkg additions:
  - lsu_state_t {IDLE, BUS, DONE}
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - memory_operation_t, already present, is reused unchanged.
- Sub-module load_align (combinational): inputs wb_dat_i, ea[1:0], funct3; output 32-bit extended data. load_store_unit instantiates it and owns all sequencing.

Test Plan:
- SW: base 0x100, offset 0, data 0xDEADBEEF, zero-wait slave → wb_adr_o=0x100, wb_sel_o=1111, wb_we_o=1, wb_dat_o=0xDEADBEEF; ack 2 edges after cyc; held until cyc=0.
- LB/LBU: ea 0x103, wb_dat_i=0x80123456 → LB load_data=0xFFFFFF80, LBU=0x00000080, wb_sel_o=1000, wb_adr_o=0x100.
- SH: base 0x100, offset 2, data 0x0000ABCD → wb_sel_o=1100, wb_dat_o=0xABCD0000. LHU at same ea with wb_dat_i=0xABCD0000 → 0x0000ABCD.
- Misaligned LW: ea 0x101 → wb_cyc_o never asserts; ack=1 and misaligned=1 one edge after cyc. Back-to-back valid request after cyc drops → exactly one bus cycle.
- Timeout and error:
  - TIMEOUT_CYCLES=16, slave silent → wb_cyc_o drops after 16 BUS cycles; ack with bus_error=1, load_data=0.
  - wb_err_i and wb_ack_i together → bus_error=1.
- Reset mid-BUS: rst_n low during wait state → wb_cyc_o=0 immediately and no ack. After release, a new LW at 0x200 completes normally.
